// File: rtl/dmem_responder.sv
// dmem_responder: SRAM-style data-port slave; mem_ready pulses WAIT_CYCLES+1 cycles after a request, stalling the core meanwhile.
// Dropping mem_en mid-wait aborts without commit. Define DMEM_STATS_EN to build the stat_* counters (tied to 0 otherwise).
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_ready,
  output logic        err_oor,
  output logic [31:0] stat_rd,
  output logic [31:0] stat_wr,
  output logic [31:0] stat_stall
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] waitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        waitCnt;
  logic [3:0]        wenQ;
  logic [31:0]       addrQ;
  logic [31:0]       wdataQ;
  logic [31:0]       memArray [2**ADDR_W];

  logic [3:0]        reqWen;
  logic [31:0]       reqAddr;
  logic [31:0]       reqWdata;
  logic [ADDR_W-1:0] reqIdx;
  logic              reqOor;
  logic              commit;

  // With zero wait states the commit edge is also the accept edge, so the live fields are used.
  always_comb begin
    reqWen   = wenQ;
    reqAddr  = addrQ;
    reqWdata = wdataQ;
    if (state == IDLE) begin
      reqWen   = mem_wen;
      reqAddr  = mem_addr;
      reqWdata = mem_wdata;
    end
  end

  assign reqIdx    = reqAddr[ADDR_W+1:2];
  assign reqOor    = (reqAddr >> (ADDR_W + 2)) != 32'd0;
  assign commit    = ((state == IDLE) && mem_en && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && mem_en && (waitCnt == 4'd0));
  assign mem_stall = ((state == IDLE) && mem_en) || (state == WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      wenQ      <= 4'd0;
      addrQ     <= 32'd0;
      wdataQ    <= 32'd0;
      mem_rdata <= 32'd0;
      mem_ready <= 1'b0;
      err_oor   <= 1'b0;
    end else begin
      mem_ready <= commit;
      if (commit) begin
        // Read-before-write: the response carries the word as it was before this commit.
        mem_rdata <= reqOor ? 32'd0 : memArray[reqIdx];
        if (reqOor) begin
          err_oor <= 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (reqWen[i]) memArray[reqIdx][8*i +: 8] <= reqWdata[8*i +: 8];
          end
        end
      end
      case (state)
        IDLE: begin
          if (mem_en) begin
            wenQ   <= mem_wen;
            addrQ  <= mem_addr;
            wdataQ <= mem_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              waitCnt <= waitLoad;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!mem_en)                state   <= IDLE;
          else if (waitCnt == 4'd0)   state   <= RESP;
          else                        waitCnt <= waitCnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] statRdQ;
  logic [31:0] statWrQ;
  logic [31:0] statStallQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      statRdQ    <= 32'd0;
      statWrQ    <= 32'd0;
      statStallQ <= 32'd0;
    end else begin
      if (mem_stall) statStallQ <= statStallQ + 32'd1;
      if (commit) begin
        if (reqWen == 4'd0) statRdQ <= statRdQ + 32'd1;
        else                statWrQ <= statWrQ + 32'd1;
      end
    end
  end

  assign stat_rd    = statRdQ;
  assign stat_wr    = statWrQ;
  assign stat_stall = statStallQ;
`else
  assign stat_rd    = 32'd0;
  assign stat_wr    = 32'd0;
  assign stat_stall = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES 1, 0 and 3.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rstN;
  logic        en    [3];
  logic [3:0]  wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        ready [3];
  logic        oor   [3];
  logic [31:0] sRd   [3];
  logic [31:0] sWr   [3];
  logic [31:0] sSt   [3];

  int tests = 0;
  int fails = 0;

  int          lat;
  int          stl;
  logic        rs;
  logic [31:0] rd;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dutA (
    .clk(clk), .rst(rstN), .mem_en(en[0]), .mem_wen(wen[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_stall(stall[0]), .mem_ready(ready[0]),
    .err_oor(oor[0]), .stat_rd(sRd[0]), .stat_wr(sWr[0]), .stat_stall(sSt[0]));

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .rst(rstN), .mem_en(en[1]), .mem_wen(wen[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_stall(stall[1]), .mem_ready(ready[1]),
    .err_oor(oor[1]), .stat_rd(sRd[1]), .stat_wr(sWr[1]), .stat_stall(sSt[1]));

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dutC (
    .clk(clk), .rst(rstN), .mem_en(en[2]), .mem_wen(wen[2]), .mem_addr(addr[2]),
    .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_stall(stall[2]), .mem_ready(ready[2]),
    .err_oor(oor[2]), .stat_rd(sRd[2]), .stat_wr(sWr[2]), .stat_stall(sSt[2]));

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge ending RESP.
  // lat is the cycle index of mem_ready (cycle 0 = first cycle the request is presented), -1 on timeout.
  task automatic doReq(input int d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rdo, output int lato, output int stallo, output logic respStall);
    rdo = 32'd0; lato = -1; stallo = 0; respStall = 1'b1;
    en[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ready[d]) begin
        lato = c; rdo = rdata[d]; respStall = stall[d];
        break;
      end
      if (stall[d]) stallo++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    en[d] = 1'b0; wen[d] = 4'd0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (rdata[d] !== 32'd0) begin fails++; $display("FAIL reset_rdata[%0d] got %h want 0", d, rdata[d]); end
      tests++;
      if (ready[d] !== 1'b0) begin fails++; $display("FAIL reset_ready[%0d] got %b want 0", d, ready[d]); end
      tests++;
      if (oor[d] !== 1'b0) begin fails++; $display("FAIL reset_oor[%0d] got %b want 0", d, oor[d]); end
      tests++;
      if (stall[d] !== 1'b0) begin fails++; $display("FAIL reset_stall[%0d] got %b want 0", d, stall[d]); end
    end
  endtask

  task automatic test_basic();
    doReq(0, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat, stl, rs);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL basic_wr_latency got %0d want 2", lat); end
    tests++;
    if (stl !== 2) begin fails++; $display("FAIL basic_wr_stall_cycles got %0d want 2", stl); end
    tests++;
    if (rs !== 1'b0) begin fails++; $display("FAIL basic_wr_stall_in_resp got %b want 0", rs); end
    doReq(0, 4'h0, 32'h10, 32'h0, rd, lat, stl, rs);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL basic_rd_latency got %0d want 2", lat); end
    tests++;
    if (stl !== 2) begin fails++; $display("FAIL basic_rd_stall_cycles got %0d want 2", stl); end
    tests++;
    if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_mask();
    doReq(0, 4'hF, 32'h20, 32'h11223344, rd, lat, stl, rs);
    doReq(0, 4'b0101, 32'h20, 32'hAABBCCDD, rd, lat, stl, rs);
    tests++;
    if (rd !== 32'h11223344) begin fails++; $display("FAIL mask_read_before_write got %h want 11223344", rd); end
    doReq(0, 4'h0, 32'h20, 32'h0, rd, lat, stl, rs);
    tests++;
    if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL mask_rd_data got %h want 11bb33dd", rd); end
  endtask

  task automatic test_back_to_back();
    doReq(1, 4'hF, 32'h0, 32'h01010101, rd, lat, stl, rs);
    doReq(1, 4'hF, 32'h4, 32'h02020202, rd, lat, stl, rs);
    doReq(1, 4'h0, 32'h0, 32'h0, rd, lat, stl, rs);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL b2b_rd0_latency got %0d want 1", lat); end
    tests++;
    if (stl !== 1) begin fails++; $display("FAIL b2b_rd0_stall_cycles got %0d want 1", stl); end
    tests++;
    if (rd !== 32'h01010101) begin fails++; $display("FAIL b2b_rd0_data got %h want 01010101", rd); end
    doReq(1, 4'h0, 32'h4, 32'h0, rd, lat, stl, rs);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL b2b_rd1_latency got %0d want 1", lat); end
    tests++;
    if (stl !== 1) begin fails++; $display("FAIL b2b_rd1_stall_cycles got %0d want 1", stl); end
    tests++;
    if (rd !== 32'h02020202) begin fails++; $display("FAIL b2b_rd1_data got %h want 02020202", rd); end
    @(posedge clk); #1;
    tests++;
    if (ready[1] !== 1'b0) begin fails++; $display("FAIL b2b_no_dup_ready got %b want 0", ready[1]); end
  endtask

  task automatic test_oor();
    doReq(0, 4'hF, 32'h0, 32'hCAFEF00D, rd, lat, stl, rs);
    tests++;
    if (oor[0] !== 1'b0) begin fails++; $display("FAIL oor_clear_before got %b want 0", oor[0]); end
    doReq(0, 4'hF, 32'h0001_0000, 32'hFFFFFFFF, rd, lat, stl, rs);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL oor_wr_latency got %0d want 2", lat); end
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL oor_wr_rdata got %h want 0", rd); end
    tests++;
    if (oor[0] !== 1'b1) begin fails++; $display("FAIL oor_flag_set got %b want 1", oor[0]); end
    doReq(0, 4'h0, 32'h0, 32'h0, rd, lat, stl, rs);
    tests++;
    if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL oor_array_unchanged got %h want cafef00d", rd); end
    doReq(0, 4'h0, 32'h8000_0004, 32'h0, rd, lat, stl, rs);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL oor_rd_data got %h want 0", rd); end
    tests++;
    if (oor[0] !== 1'b1) begin fails++; $display("FAIL oor_flag_sticky got %b want 1", oor[0]); end
  endtask

  task automatic test_abort();
    int seenReady;
    doReq(2, 4'hF, 32'h8, 32'h12345678, rd, lat, stl, rs);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL abort_wait3_latency got %0d want 4", lat); end
    tests++;
    if (stl !== 4) begin fails++; $display("FAIL abort_wait3_stall_cycles got %0d want 4", stl); end
    en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h8; wdata[2] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en[2] = 1'b0; wen[2] = 4'h0;
    seenReady = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ready[2]) seenReady++;
    end
    tests++;
    if (seenReady !== 0) begin fails++; $display("FAIL abort_no_ready got %0d pulses want 0", seenReady); end
    tests++;
    if (stall[2] !== 1'b0) begin fails++; $display("FAIL abort_back_to_idle stall got %b want 0", stall[2]); end
    doReq(2, 4'h0, 32'h8, 32'h0, rd, lat, stl, rs);
    tests++;
    if (rd !== 32'h12345678) begin fails++; $display("FAIL abort_no_commit got %h want 12345678", rd); end

    en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h8; wdata[2] = 32'h0BADF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    tests++;
    if (rdata[2] !== 32'd0) begin fails++; $display("FAIL midreset_rdata got %h want 0", rdata[2]); end
    tests++;
    if (ready[2] !== 1'b0) begin fails++; $display("FAIL midreset_ready got %b want 0", ready[2]); end
    tests++;
    if (oor[0] !== 1'b0) begin fails++; $display("FAIL midreset_oor_cleared got %b want 0", oor[0]); end
    en[2] = 1'b0; wen[2] = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    doReq(2, 4'h0, 32'h8, 32'h0, rd, lat, stl, rs);
    tests++;
    if (rd !== 32'h12345678) begin fails++; $display("FAIL midreset_no_commit got %h want 12345678", rd); end
  endtask

  task automatic test_stats();
    logic [31:0] expRd, expWr, expSt;
`ifdef DMEM_STATS_EN
    expRd = 32'd3; expWr = 32'd2; expSt = 32'd10;
`else
    expRd = 32'd0; expWr = 32'd0; expSt = 32'd0;
`endif
    doReq(0, 4'hF, 32'h40, 32'h00000001, rd, lat, stl, rs);
    doReq(0, 4'h0, 32'h40, 32'h0, rd, lat, stl, rs);
    doReq(0, 4'h3, 32'h44, 32'h00000002, rd, lat, stl, rs);
    doReq(0, 4'h0, 32'h44, 32'h0, rd, lat, stl, rs);
    doReq(0, 4'h0, 32'h10, 32'h0, rd, lat, stl, rs);
    tests++;
    if (sRd[0] !== expRd) begin fails++; $display("FAIL stat_rd got %0d want %0d", sRd[0], expRd); end
    tests++;
    if (sWr[0] !== expWr) begin fails++; $display("FAIL stat_wr got %0d want %0d", sWr[0], expWr); end
    tests++;
    if (sSt[0] !== expSt) begin fails++; $display("FAIL stat_stall got %0d want %0d", sSt[0], expSt); end
  endtask

  initial begin
    rstN = 1'b0;
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0; wen[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rstN = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_byte_mask();
    test_back_to_back();
    test_oor();
    test_abort();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
